// File: rtl/mult_arbiter_pkg.sv
// Shared types and timing constants for the multiplier arbiter.
package mult_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_e;
  localparam int MUL_LAT = 2;  // mul_go cycle to product-valid cycle
  localparam int MUL_II  = 2;  // minimum cycles between mul_go pulses
endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Round-robin picker: grants the first asserted request at or after ptr, wrapping.
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one 2-cycle multiplier among NREQ requesters with round-robin
// arbitration; one issue every two cycles, results tagged back to the issuer.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_left,
  input  logic [NREQ*WIDTH-1:0] req_right,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  mul_go,
  output logic [WIDTH-1:0]      mul_left,
  output logic [WIDTH-1:0]      mul_right,
  input  logic [WIDTH-1:0]      mul_out
);
  localparam int IDW = $clog2(NREQ);

  state_e                      state_q, state_d;
  logic [IDW-1:0]              ptr_q, ptr_d;
  logic [IDW-1:0]              op_id_q, op_id_d;
  logic [WIDTH-1:0]            op_left_q, op_left_d;
  logic [WIDTH-1:0]            op_right_q, op_right_d;
  logic [MUL_LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            arb_en, xfer;

  rr_picker #(.N(NREQ), .IDW(IDW)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // ISSUE is the only state that cannot accept: it enforces the 2-cycle II.
  assign arb_en = (state_q != ISSUE) && !reset;
  assign xfer   = arb_en && pick_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      op_id_q    <= '0;
      op_left_q  <= '0;
      op_right_q <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_id_q    <= op_id_d;
      op_left_q  <= op_left_d;
      op_right_q <= op_right_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = xfer ? ISSUE : IDLE;
      ISSUE:   state_d = HOLD;
      HOLD:    state_d = xfer ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    op_id_d    = op_id_q;
    op_left_d  = op_left_q;
    op_right_d = op_right_q;
    if (xfer) begin
      op_id_d    = pick_idx;
      op_left_d  = req_left[int'(pick_idx)*WIDTH +: WIDTH];
      op_right_d = req_right[int'(pick_idx)*WIDTH +: WIDTH];
      ptr_d      = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);
    end
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = (state_q == ISSUE);
    tag_id_d[0]  = op_id_q;
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  always_comb begin
    req_ready  = arb_en ? pick_gnt : '0;
    mul_go     = 1'b0;
    mul_left   = '0;
    mul_right  = '0;
    resp_valid = '0;
    resp_data  = '0;
    if (!reset) begin
      mul_go    = (state_q == ISSUE);
      mul_left  = op_left_q;
      mul_right = op_right_q;
      if (tag_vld_q[MUL_LAT-1]) begin
        resp_valid[tag_id_q[MUL_LAT-1]] = 1'b1;
        resp_data                       = mul_out;
      end
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, scoreboard, corner sequences.
module tb_mult_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, resp_valid;
  logic [NREQ*W-1:0] req_left, req_right;
  logic [W-1:0]      resp_data, mul_left, mul_right, mul_out;
  logic              mul_go;

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_left(req_left), .req_right(req_right), .resp_valid(resp_valid),
    .resp_data(resp_data), .mul_go(mul_go), .mul_left(mul_left),
    .mul_right(mul_right), .mul_out(mul_out)
  );

  // Multiplier model: right taken at T, left at T+1, product shown only in T+2.
  logic         m_go1;
  logic [W-1:0] m_r1, m_prod;
  always @(posedge clk) begin
    m_go1  <= mul_go;
    m_r1   <= mul_right;
    m_prod <= m_go1 ? mul_left * m_r1 : 32'hDEAD_BEEF;
  end
  assign mul_out = m_prod;

  typedef struct { int id; logic [31:0] exp; int cyc; } sb_t;
  typedef struct { int id; logic [31:0] l; logic [31:0] r; logic [31:0] exp; } vec_t;

  sb_t          sb[$];
  int           gnt_log[$], go_log[$], rsp_cyc[$];
  logic [31:0]  rsp_log[$];
  int           n_cmp, n_fail, cyc;
  int           rem[NREQ];
  vec_t         vecs[5];
  logic [NREQ-1:0] s_hs, s_ready, s_rv;
  logic [W-1:0] s_rd, s_left, s_right;
  logic         s_go;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon();
    sb_t e;
    s_ready = req_ready; s_rv = resp_valid; s_rd = resp_data;
    s_go = mul_go; s_left = mul_left; s_right = mul_right;
    s_hs = req_valid & req_ready;
    if (reset) begin
      chk("rst_outputs_zero",
          64'(|{req_ready, resp_valid, resp_data, mul_go, mul_left, mul_right}), 64'd0);
      sb.delete();
    end else begin
      chk("ready_at_most_one", 64'($countones(req_ready) <= 1), 64'd1);
      if (mul_go) begin
        chk("ready_zero_in_issue", 64'(req_ready), 64'd0);
        go_log.push_back(cyc);
      end
      for (int i = 0; i < NREQ; i++) if (s_hs[i]) begin
        gnt_log.push_back(i);
        e.id  = i;
        e.exp = req_left[i*W +: W] * req_right[i*W +: W];
        e.cyc = cyc + 3;
        sb.push_back(e);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("resp_missing", 64'(cyc), 64'(sb[0].cyc));
        e = sb.pop_front();
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
        else begin
          e = sb.pop_front();
          chk("resp_valid_id", 64'(resp_valid), 64'd1 << e.id);
          chk("resp_data", 64'(resp_data), 64'(e.exp));
          chk("resp_latency", 64'(cyc), 64'(e.cyc));
          rsp_log.push_back(resp_data);
          rsp_cyc.push_back(cyc);
        end
      end else chk("idle_resp_data_zero", 64'(resp_data), 64'd0);
    end
  endtask

  task automatic load(input int i);
    req_left[i*W +: W]  = 32'(i*16 + rem[i] + 1);
    req_right[i*W +: W] = 32'(rem[i]*3 + 2);
  endtask

  task automatic set_req(input int i, input logic [31:0] l, input logic [31:0] r);
    req_left[i*W +: W]  = l;
    req_right[i*W +: W] = r;
    rem[i]       = 1;
    req_valid[i] = 1'b1;
  endtask

  // One cycle: sample at negedge, then retire/reload accepted requests after the edge.
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) if (s_hs[i]) begin
      rem[i]--;
      if (rem[i] > 0) load(i);
      else req_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_hs(input string nm);
    int k;
    k = 0;
    do begin step(); k++; end while (s_hs == '0 && k < 12);
    chk(nm, 64'(s_hs != '0), 64'd1);
  endtask

  task automatic rst(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); go_log.delete(); rsp_log.delete(); rsp_cyc.delete();
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_left = '0; req_right = '0;
    n_cmp = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    vecs[0] = '{0, 32'd3,          32'd5,       32'd15};
    vecs[1] = '{2, 32'hFFFF_FFFF,  32'd2,       32'hFFFF_FFFE};
    vecs[2] = '{3, 32'h0001_0000,  32'h0001_0000, 32'd0};
    vecs[3] = '{1, 32'd7,          32'd0,       32'd0};
    vecs[4] = '{1, 32'h0001_2345,  32'h100,     32'h0123_4500};

    rst(3);

    // Single requests: go one cycle after transfer, left held two cycles, result at +3.
    foreach (vecs[v]) begin
      set_req(vecs[v].id, vecs[v].l, vecs[v].r);
      wait_hs("tbl_grant");
      step();
      chk("tbl_go_T", 64'(s_go), 64'd1);
      chk("tbl_left_T", 64'(s_left), 64'(vecs[v].l));
      chk("tbl_right_T", 64'(s_right), 64'(vecs[v].r));
      step();
      chk("tbl_go_T1", 64'(s_go), 64'd0);
      chk("tbl_left_T1", 64'(s_left), 64'(vecs[v].l));
      step();
      chk("tbl_resp_valid", 64'(s_rv), 64'd1 << vecs[v].id);
      chk("tbl_resp_data", 64'(s_rd), 64'(vecs[v].exp));
      step();
    end

    // Contention from pointer 0.
    rst(2);
    clear_logs();
    set_req(1, 32'd6, 32'd7);
    set_req(2, 32'd2, 32'd9);
    repeat (10) step();
    chk("cont_grants", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() == 2) begin
      chk("cont_first", 64'(gnt_log[0]), 64'd1);
      chk("cont_second", 64'(gnt_log[1]), 64'd2);
    end
    chk("cont_resps", 64'(rsp_log.size()), 64'd2);
    if (rsp_log.size() == 2) begin
      chk("cont_r0", 64'(rsp_log[0]), 64'd42);
      chk("cont_r1", 64'(rsp_log[1]), 64'd18);
      chk("cont_r_gap", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'd2);
    end

    // Fairness: all four held valid, two ops each.
    rst(2);
    clear_logs();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 2; load(i); req_valid[i] = 1'b1;
    end
    repeat (22) step();
    chk("fair_grants", 64'(gnt_log.size()), 64'd8);
    if (gnt_log.size() == 8)
      for (int k = 0; k < 8; k++) chk("fair_order", 64'(gnt_log[k]), 64'(k % 4));
    chk("fair_gos", 64'(go_log.size()), 64'd8);
    if (go_log.size() == 8)
      for (int k = 1; k < 8; k++) chk("fair_go_gap", 64'(go_log[k] - go_log[k-1]), 64'd2);

    // A request raised in ISSUE and dropped before HOLD must never issue.
    clear_logs();
    set_req(1, 32'd4, 32'd4);
    wait_hs("drop_grant");
    set_req(3, 32'd9, 32'd9);
    step();
    chk("drop_ready_issue", 64'(s_ready), 64'd0);
    req_valid[3] = 1'b0; rem[3] = 0;
    begin
      int n_go;
      n_go = go_log.size();
      repeat (5) step();
      chk("drop_no_issue", 64'(go_log.size() - n_go), 64'd0);
    end
    chk("drop_grant_count", 64'(gnt_log.size()), 64'd1);

    // Reset while in HOLD drops the op; pointer restarts at 0.
    set_req(2, 32'd11, 32'd13);
    wait_hs("rh_grant");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_logs();
    set_req(1, 32'd5, 32'd6);
    set_req(3, 32'd7, 32'd8);
    step();
    chk("rh_accept_first", 64'(s_hs), 64'(4'b0010));
    repeat (8) step();
    chk("rh_resps", 64'(rsp_log.size()), 64'd2);
    if (rsp_log.size() == 2) begin
      chk("rh_r0", 64'(rsp_log[0]), 64'd30);
      chk("rh_r1", 64'(rsp_log[1]), 64'd56);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
